// File: rtl/dcpu16_pkg.sv
// Shared definitions for the DCPU16 sequential execute unit: default data
// width, basic opcode encodings and the FSM state encoding.
package dcpu16_pkg;

  localparam int DCPU16_DW = 16;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_SET = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_MUL = 4'h4;
  localparam logic [3:0] OP_DIV = 4'h5;
  localparam logic [3:0] OP_MOD = 4'h6;
  localparam logic [3:0] OP_SHL = 4'h7;
  localparam logic [3:0] OP_SHR = 4'h8;
  localparam logic [3:0] OP_AND = 4'h9;
  localparam logic [3:0] OP_BOR = 4'hA;
  localparam logic [3:0] OP_XOR = 4'hB;
  localparam logic [3:0] OP_IFE = 4'hC;
  localparam logic [3:0] OP_IFN = 4'hD;
  localparam logic [3:0] OP_IFG = 4'hE;
  localparam logic [3:0] OP_IFB = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

  function automatic logic is_div_op(input logic [3:0] opc);
    return (opc == OP_DIV) || (opc == OP_MOD);
  endfunction

endpackage

// File: rtl/dcpu16_alu_seq_if.sv
// Request/response bundle of the DCPU16 execute unit.
// Handshake: start is a one-cycle request, opc/src_a/src_b are sampled in
// the same cycle; it is accepted only when ena=1 and the unit is idle
// (busy=0), otherwise it is dropped. done pulses for one cycle when
// res/regO/cond_ok hold the result. dbg_state mirrors the FSM state.
interface dcpu16_alu_seq_if
  import dcpu16_pkg::*;
#(
  parameter int DW = DCPU16_DW
);
  logic          start;
  logic [3:0]    opc;
  logic [DW-1:0] src_a;
  logic [DW-1:0] src_b;
  logic          busy;
  logic          done;
  logic [DW-1:0] res;
  logic [DW-1:0] regO;
  logic          cond_ok;
  alu_state_t    dbg_state;

  modport master (
    output start, opc, src_a, src_b,
    input  busy, done, res, regO, cond_ok, dbg_state
  );

  modport slave (
    input  start, opc, src_a, src_b,
    output busy, done, res, regO, cond_ok, dbg_state
  );
endinterface

// File: rtl/dcpu16_div.sv
// Iterative restoring divider: one quotient bit per enabled cycle.
// go loads the 2*DW dividend and the divisor and clears the counter; every
// following enabled cycle shifts one dividend bit into the partial remainder.
// After DW steps rem_lo holds (dividend_hi % divisor); after 2*DW steps quot
// holds the full quotient. The unit keeps stepping until the next go; the
// caller samples the outputs at the step count it needs.
module dcpu16_div #(
  parameter int DW = 16,
  parameter int CW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic            go,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic [2*DW-1:0] quot,
  output logic [DW-1:0]   rem_lo,
  output logic [CW-1:0]   count
);

  logic [2*DW-1:0] q_q;
  logic [DW-1:0]   r_q;
  logic [DW-1:0]   d_q;
  logic [CW-1:0]   cnt_q;
  logic [DW:0]     trial;
  logic [DW:0]     diff;
  logic            fits;

  // Partial remainder shifted left by one with the next dividend bit.
  assign trial = {r_q, q_q[2*DW-1]};
  assign diff  = trial - {1'b0, d_q};
  assign fits  = (trial >= {1'b0, d_q});

  // Load on go, otherwise perform one restoring step.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= '0;
      r_q   <= '0;
      d_q   <= '0;
      cnt_q <= '0;
    end else if (ena) begin
      if (go) begin
        q_q   <= dividend;
        r_q   <= '0;
        d_q   <= divisor;
        cnt_q <= '0;
      end else begin
        q_q   <= {q_q[2*DW-2:0], fits};
        r_q   <= fits ? diff[DW-1:0] : trial[DW-1:0];
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign quot   = q_q;
  assign rem_lo = r_q;
  assign count  = cnt_q;

endmodule

// File: rtl/dcpu16_alu_seq.sv
// DCPU16 sequential execute unit: basic opcodes 0x1-0xF with a start/done
// handshake, overflow register O and IFx condition output.
// Build option DCPU16_ALU_DIV_EN: when defined, DIV/MOD with a nonzero
// divisor run on the iterative divider (DW+2 cycles for MOD, 2*DW+2 for
// DIV). When undefined, no divider is built, busy is tied low and DIV/MOD
// finish in one cycle with res=0.
module dcpu16_alu_seq
  import dcpu16_pkg::*;
#(
  parameter int DW = DCPU16_DW,
  parameter int CW = 5
) (
  input logic                clk,
  input logic                rst,
  input logic                ena,
  dcpu16_alu_seq_if.slave    bus
);

  alu_state_t    state;
  logic [DW-1:0] res_q;
  logic [DW-1:0] o_q;
  logic          cond_q;
  logic          done_q;

  logic [DW-1:0]   a;
  logic [DW-1:0]   b;
  logic [DW:0]     add_w;
  logic [2*DW-1:0] mul_w;
  logic [2*DW-1:0] shl_w;
  logic [2*DW-1:0] shr_w;
  logic            b_big;
  logic [DW-1:0]   sc_res;
  logic [DW-1:0]   sc_o;
  logic            sc_cond;

  assign a     = bus.src_a;
  assign b     = bus.src_b;
  assign add_w = {1'b0, a} + {1'b0, b};
  assign mul_w = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
  assign shl_w = {{DW{1'b0}}, a} << b;
  assign shr_w = {a, {DW{1'b0}}} >> b;
  assign b_big = (b >= DW'(2 * DW));

  // Single-cycle results; DIV/MOD here cover the divide-by-zero case
  // and the build without a divider.
  always_comb begin
    sc_res  = res_q;
    sc_o    = o_q;
    sc_cond = 1'b1;
    case (bus.opc)
      OP_NOP: sc_cond = cond_q;
      OP_SET: sc_res = b;
      OP_ADD: begin
        sc_res = add_w[DW-1:0];
        sc_o   = {{(DW-1){1'b0}}, add_w[DW]};
      end
      OP_SUB: begin
        sc_res = a - b;
        sc_o   = (a < b) ? '1 : '0;
      end
      OP_MUL: begin
        sc_res = mul_w[DW-1:0];
        sc_o   = mul_w[2*DW-1:DW];
      end
      OP_DIV: begin
        sc_res = '0;
        sc_o   = '0;
      end
      OP_MOD: sc_res = '0;
      OP_SHL: begin
        sc_res = b_big ? '0 : shl_w[DW-1:0];
        sc_o   = b_big ? '0 : shl_w[2*DW-1:DW];
      end
      OP_SHR: begin
        sc_res = b_big ? '0 : shr_w[2*DW-1:DW];
        sc_o   = b_big ? '0 : shr_w[DW-1:0];
      end
      OP_AND: sc_res = a & b;
      OP_BOR: sc_res = a | b;
      OP_XOR: sc_res = a ^ b;
      OP_IFE: sc_cond = (a == b);
      OP_IFN: sc_cond = (a != b);
      OP_IFG: sc_cond = (a > b);
      OP_IFB: sc_cond = ((a & b) != '0);
      default: sc_cond = 1'b1;
    endcase
  end

`ifdef DCPU16_ALU_DIV_EN
  logic            busy_q;
  logic [3:0]      op_q;
  logic            div_go;
  logic [2*DW-1:0] div_quot;
  logic [DW-1:0]   div_rem;
  logic [CW-1:0]   div_count;
  logic [CW-1:0]   div_last;

  assign div_go   = (state == ST_IDLE) && bus.start && is_div_op(bus.opc) && (b != '0);
  // Count value seen before the final step: MOD stops after DW steps,
  // DIV after 2*DW steps.
  assign div_last = (op_q == OP_DIV) ? CW'(2 * DW - 1) : CW'(DW - 1);

  dcpu16_div #(
    .DW (DW),
    .CW (CW)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .go       (div_go),
    .dividend ({a, {DW{1'b0}}}),
    .divisor  (b),
    .quot     (div_quot),
    .rem_lo   (div_rem),
    .count    (div_count)
  );
`endif

  // Control FSM with registered outputs; ena low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      res_q  <= '0;
      o_q    <= '0;
      cond_q <= 1'b1;
      done_q <= 1'b0;
`ifdef DCPU16_ALU_DIV_EN
      busy_q <= 1'b0;
      op_q   <= OP_NOP;
`endif
    end else if (ena) begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
`ifdef DCPU16_ALU_DIV_EN
          if (div_go) begin
            state  <= ST_DIV;
            busy_q <= 1'b1;
            op_q   <= bus.opc;
          end else if (bus.start) begin
`else
          if (bus.start) begin
`endif
            res_q  <= sc_res;
            o_q    <= sc_o;
            cond_q <= sc_cond;
            done_q <= 1'b1;
          end
        end
`ifdef DCPU16_ALU_DIV_EN
        ST_DIV: begin
          if (div_count == div_last) state <= ST_DONE;
        end
        ST_DONE: begin
          if (op_q == OP_DIV) begin
            res_q <= div_quot[2*DW-1:DW];
            o_q   <= div_quot[DW-1:0];
          end else begin
            res_q <= div_rem;
          end
          cond_q <= 1'b1;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DCPU16_ALU_DIV_EN
  assign bus.busy = busy_q;
`else
  assign bus.busy = 1'b0;
`endif
  assign bus.done      = done_q;
  assign bus.res       = res_q;
  assign bus.regO      = o_q;
  assign bus.cond_ok   = cond_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_dcpu16_alu_seq.sv
// Directed bench for dcpu16_alu_seq (DW=16). Expected values are hand
// computed; the divider section follows the DCPU16_ALU_DIV_EN build option.
module tb_dcpu16_alu_seq;
  import dcpu16_pkg::*;

  localparam int DW = 16;

  logic clk;
  logic rst;
  logic ena;
  int   n_checks;
  int   n_fail;
  int   lat;
  logic bsy;
  int   n_done;

  dcpu16_alu_seq_if #(.DW(DW)) bus ();

  dcpu16_alu_seq #(.DW(DW), .CW(5)) dut (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .bus (bus)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Issue one request at a negedge and wait for done (bounded). Optional
  // events relative to the start cycle: stall_at drops ena for 5 cycles,
  // inject_at pulses a second start, rst_at pulses reset. lat=-1 if no done.
  task automatic run_op(input logic [3:0] opc, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input int stall_at, input int inject_at, input int rst_at,
                        output int lat_o, output logic busy_o);
    lat_o  = -1;
    busy_o = 1'b0;
    bus.start = 1'b1;
    bus.opc   = opc;
    bus.src_a = a;
    bus.src_b = b;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (stall_at > 0 && c == stall_at) ena = 1'b0;
      if (stall_at > 0 && c == stall_at + 5) ena = 1'b1;
      if (inject_at > 0 && c == inject_at) begin
        bus.start = 1'b1;
        bus.opc   = OP_ADD;
        bus.src_a = 16'h0001;
        bus.src_b = 16'h0001;
      end
      if (inject_at > 0 && c == inject_at + 1) bus.start = 1'b0;
      if (rst_at > 0 && c == rst_at) rst = 1'b1;
      if (rst_at > 0 && c == rst_at + 1) rst = 1'b0;
      if (bus.done) begin
        lat_o = c;
        break;
      end
      busy_o = busy_o | bus.busy;
    end
  endtask

  task automatic op(input logic [3:0] opc, input logic [DW-1:0] a, input logic [DW-1:0] b);
    run_op(opc, a, b, 0, 0, 0, lat, bsy);
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (bus.done) n++;
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    ena       = 1'b1;
    bus.start = 1'b0;
    bus.opc   = OP_NOP;
    bus.src_a = '0;
    bus.src_b = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_res", bus.res, 16'h0000);
    check_eq("rst_o", bus.regO, 16'h0000);
    check_eq("rst_cond", bus.cond_ok, 1'b1);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_done", bus.done, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    op(OP_ADD, 16'hFFFF, 16'h0002);
    check_eq("add_res", bus.res, 16'h0001); check_eq("add_o", bus.regO, 16'h0001);
    check_eq("add_lat", lat, 1); check_eq("add_busy", bsy, 1'b0);
    op(OP_SUB, 16'h0001, 16'h0002);
    check_eq("sub_res", bus.res, 16'hFFFF); check_eq("sub_o", bus.regO, 16'hFFFF);
    op(OP_MUL, 16'h1234, 16'h0100);
    check_eq("mul_res", bus.res, 16'h3400); check_eq("mul_o", bus.regO, 16'h0012);
    op(OP_SET, 16'h0000, 16'hBEEF);
    check_eq("set_res", bus.res, 16'hBEEF); check_eq("set_o", bus.regO, 16'h0012);
    op(OP_SHL, 16'h8001, 16'h0001);
    check_eq("shl_res", bus.res, 16'h0002); check_eq("shl_o", bus.regO, 16'h0001);
    op(OP_SHL, 16'h0001, 16'd40);
    check_eq("shl40_res", bus.res, 16'h0000); check_eq("shl40_o", bus.regO, 16'h0000);
    op(OP_SHR, 16'h0003, 16'h0001);
    check_eq("shr_res", bus.res, 16'h0001); check_eq("shr_o", bus.regO, 16'h8000);
    op(OP_IFG, 16'h0003, 16'h0005);
    check_eq("ifg_cond", bus.cond_ok, 1'b0); check_eq("ifg_res", bus.res, 16'h0001);
    check_eq("ifg_o", bus.regO, 16'h8000); check_eq("ifg_lat", lat, 1);
    op(OP_AND, 16'hF0F0, 16'h0FF0);
    check_eq("and_res", bus.res, 16'h00F0); check_eq("and_cond", bus.cond_ok, 1'b1);
    check_eq("and_o", bus.regO, 16'h8000);
    op(OP_IFE, 16'h0005, 16'h0005); check_eq("ife_cond", bus.cond_ok, 1'b1);
    op(OP_IFN, 16'h0005, 16'h0005); check_eq("ifn_cond", bus.cond_ok, 1'b0);
    op(OP_IFG, 16'h0005, 16'h0003); check_eq("ifg2_cond", bus.cond_ok, 1'b1);
    op(OP_IFB, 16'h0006, 16'h0001); check_eq("ifb0_cond", bus.cond_ok, 1'b0);
    op(OP_IFB, 16'h0006, 16'h0002); check_eq("ifb1_cond", bus.cond_ok, 1'b1);
    op(OP_BOR, 16'hFF00, 16'h0FF0); check_eq("bor_res", bus.res, 16'hFFF0);
    op(OP_XOR, 16'hFF00, 16'h0FF0); check_eq("xor_res", bus.res, 16'hF0F0);
    op(OP_NOP, 16'h0001, 16'h0002);
    check_eq("nop_res", bus.res, 16'hF0F0); check_eq("nop_o", bus.regO, 16'h8000);
    check_eq("nop_lat", lat, 1);

    op(OP_ADD, 16'hFFFF, 16'h0002);
    op(OP_DIV, 16'h0005, 16'h0000);
    check_eq("div0_res", bus.res, 16'h0000); check_eq("div0_o", bus.regO, 16'h0000);
    check_eq("div0_lat", lat, 1);
    op(OP_ADD, 16'hFFFF, 16'h0002);
    op(OP_MOD, 16'h0007, 16'h0000);
    check_eq("mod0_res", bus.res, 16'h0000); check_eq("mod0_o", bus.regO, 16'h0001);
    check_eq("mod0_lat", lat, 1);

    // start while ena is low is dropped
    ena = 1'b0;
    bus.start = 1'b1; bus.opc = OP_SET; bus.src_a = '0; bus.src_b = 16'h1111;
    @(negedge clk);
    bus.start = 1'b0;
    ena = 1'b1;
    count_done(3, n_done);
    check_eq("ena_low_done", n_done, 0); check_eq("ena_low_res", bus.res, 16'h0000);

`ifdef DCPU16_ALU_DIV_EN
    op(OP_DIV, 16'h0007, 16'h0002);
    check_eq("div_res", bus.res, 16'h0003); check_eq("div_o", bus.regO, 16'h8000);
    check_eq("div_lat", lat, 34); check_eq("div_busy", bsy, 1'b1);
    check_eq("div_busy_end", bus.busy, 1'b0);
    op(OP_MOD, 16'h0007, 16'h0002);
    check_eq("mod_res", bus.res, 16'h0001); check_eq("mod_o", bus.regO, 16'h8000);
    check_eq("mod_lat", lat, 18);
    op(OP_DIV, 16'hFFFF, 16'h0003);
    check_eq("div3_res", bus.res, 16'h5555); check_eq("div3_o", bus.regO, 16'h0000);
    op(OP_MOD, 16'd100, 16'd7);
    check_eq("mod7_res", bus.res, 16'h0002); check_eq("mod7_o", bus.regO, 16'h0000);
    op(OP_IFE, 16'h0001, 16'h0002);
    op(OP_MOD, 16'd9, 16'd4);
    check_eq("mod_cond", bus.cond_ok, 1'b1); check_eq("mod4_res", bus.res, 16'h0001);

    run_op(OP_DIV, 16'h0007, 16'h0002, 3, 0, 0, lat, bsy);
    check_eq("stall_lat", lat, 39); check_eq("stall_res", bus.res, 16'h0003);

    run_op(OP_DIV, 16'h0007, 16'h0002, 0, 5, 0, lat, bsy);
    check_eq("inject_lat", lat, 34); check_eq("inject_res", bus.res, 16'h0003);
    check_eq("inject_o", bus.regO, 16'h8000);
    count_done(5, n_done);
    check_eq("inject_extra_done", n_done, 0);

    run_op(OP_DIV, 16'h0007, 16'h0002, 0, 0, 11, lat, bsy);
    check_eq("abort_no_done", lat, -1); check_eq("abort_busy", bus.busy, 1'b0);
    check_eq("abort_res", bus.res, 16'h0000); check_eq("abort_o", bus.regO, 16'h0000);
    check_eq("abort_cond", bus.cond_ok, 1'b1);
`else
    op(OP_DIV, 16'h0007, 16'h0002);
    check_eq("div_res", bus.res, 16'h0000); check_eq("div_o", bus.regO, 16'h0000);
    check_eq("div_lat", lat, 1); check_eq("div_busy", bsy, 1'b0);
    op(OP_ADD, 16'hFFFF, 16'h0002);
    op(OP_MOD, 16'h0007, 16'h0002);
    check_eq("mod_res", bus.res, 16'h0000); check_eq("mod_o", bus.regO, 16'h0001);
    check_eq("mod_lat", lat, 1);
`endif

    // unit still works after the above
    op(OP_ADD, 16'h0010, 16'h0020);
    check_eq("final_add_res", bus.res, 16'h0030); check_eq("final_add_o", bus.regO, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
